// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Resolves B / CBZ / CBNZ branches for the LEGv8 pipeline. A decoded
//   branch is accepted from ID. An unconditional branch is taken immediately.
//   A conditional branch stalls IF/ID until EX reports the ALU zero flag.
//   Taken branches raise a one-cycle PC-select pulse with the target, then
//   squash IF/ID for FLUSH_CYCLES cycles. Saturating taken / not-taken
//   statistics are kept.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous, active-high reset
//   br_valid_i     ID presents a branch this cycle
//   br_uncond_i    B (always taken)
//   br_cbz_i       CBZ: taken when zero = 1
//   br_cbnz_i      CBNZ: taken when zero = 0
//   br_target_i    computed branch target
//   zero_valid_i   EX zero flag valid this cycle
//   alu_zero_i     ALU zero flag
//   pc_src_o       one-cycle pulse: PC loads pc_target_o
//   pc_target_o    latched target, valid while pc_src_o = 1
//   flush_o        squash IF/ID contents
//   stall_o        hold IF/ID; upstream keeps br_* stable
//   illegal_o      one-cycle pulse: more than one type bit set on an accepted branch
//   taken_cnt_o    saturating taken count
//   ntaken_cnt_o   saturating not-taken count
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | ready to accept a branch from ID
// S_WAIT    | conditional branch latched, stalling until the zero flag is valid
// S_FLUSH   | taken branch issued, flush held for FLUSH_CYCLES cycles
module branch_resolve_ctrl #(
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              br_valid_i,
  input  logic              br_uncond_i,
  input  logic              br_cbz_i,
  input  logic              br_cbnz_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              zero_valid_i,
  input  logic              alu_zero_i,
  output logic              pc_src_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  taken_cnt_o,
  output logic [CNT_W-1:0]  ntaken_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // The flush counter counts the cycles that remain after the current one,
  // so it is loaded with FLUSH_CYCLES-1 on the pc_src edge.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic              pc_src_q;
  logic [ADDR_W-1:0] pc_target_q;
  logic              flush_q;
  logic              stall_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  taken_cnt_q;
  logic [CNT_W-1:0]  ntaken_cnt_q;
  logic [3:0]        flush_cnt_q;
  logic              is_cbz_q;
  logic [ADDR_W-1:0] lat_target_q;

  logic [CNT_W-1:0]  taken_cnt_d;
  logic [CNT_W-1:0]  ntaken_cnt_d;
  logic              multi_type;
  logic              cond_taken;

  assign taken_cnt_d  = (&taken_cnt_q)  ? taken_cnt_q  : taken_cnt_q  + CNT_ONE;
  assign ntaken_cnt_d = (&ntaken_cnt_q) ? ntaken_cnt_q : ntaken_cnt_q + CNT_ONE;
  assign multi_type   = (br_uncond_i & br_cbz_i) | (br_uncond_i & br_cbnz_i) |
                        (br_cbz_i & br_cbnz_i);
  assign cond_taken   = is_cbz_q ? alu_zero_i : ~alu_zero_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pc_src_q     <= 1'b0;
      pc_target_q  <= '0;
      flush_q      <= 1'b0;
      stall_q      <= 1'b0;
      illegal_q    <= 1'b0;
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
      flush_cnt_q  <= '0;
      is_cbz_q     <= 1'b0;
      lat_target_q <= '0;
    end else begin
      pc_src_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // zero_valid here belongs to an older instruction and is ignored.
          if (br_valid_i) begin
            illegal_q <= multi_type;
            if (br_uncond_i) begin
              pc_src_q    <= 1'b1;
              pc_target_q <= br_target_i;
              taken_cnt_q <= taken_cnt_d;
              flush_q     <= 1'b1;
              flush_cnt_q <= FLUSH_LOAD;
              state_q     <= S_FLUSH;
            end else if (br_cbz_i || br_cbnz_i) begin
              // cbz wins over cbnz when both are set
              is_cbz_q     <= br_cbz_i;
              lat_target_q <= br_target_i;
              stall_q      <= 1'b1;
              state_q      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (zero_valid_i) begin
            stall_q <= 1'b0;
            if (cond_taken) begin
              pc_src_q    <= 1'b1;
              pc_target_q <= lat_target_q;
              taken_cnt_q <= taken_cnt_d;
              flush_q     <= 1'b1;
              flush_cnt_q <= FLUSH_LOAD;
              state_q     <= S_FLUSH;
            end else begin
              ntaken_cnt_q <= ntaken_cnt_d;
              state_q      <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == 4'd0) begin
            flush_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc_src_o     = pc_src_q;
  assign pc_target_o  = pc_target_q;
  assign flush_o      = flush_q;
  assign stall_o      = stall_q;
  assign illegal_o    = illegal_q;
  assign taken_cnt_o  = taken_cnt_q;
  assign ntaken_cnt_o = ntaken_cnt_q;

endmodule
